// File: rtl/seg7_scan_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seg7_pkg                                                |
// | Purpose  : Shared glyph constants, segment encoder, conversion FSM |
// |            state type and power-of-ten helper for seg7_scan_mux.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package seg7_pkg;

   // Segment order is {G,F,E,D,C,B,A}, active-high before pin polarity
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   // Decimal digit to glyph; non-decimal BCD codes render blank
   function automatic logic [6:0] seg7_encode(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   // 10^n as a 32-bit constant; n is at most 8 so the result always fits
   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int k = 0; k < n; k++) begin
         r = r * 32'd10;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seg7_scan_mux_if                                        |
// | Purpose  : Load/busy handshake plus display pins of seg7_scan_mux. |
// |            master = value producer, slave = display driver.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface seg7_scan_mux_if #(
   parameter int W = 16,
   parameter int N = 4
);
   logic [W-1:0] value;
   logic         load;
   logic         busy;
   logic         overflow;
   logic [N-1:0] an;
   logic [6:0]   seg;

   modport master (output value, load, input busy, overflow, an, seg);
   modport slave  (input value, load, output busy, overflow, an, seg);
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux_bin2bcd.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bin2bcd_seq                                             |
// | Purpose  : Sequential double-dabble converter, one bit per cycle.  |
// |            IDLE -> SHIFT (W cycles) -> COMMIT (done=1) -> IDLE.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int W  = 16,
   parameter int ND = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    bin,
   output logic            done,
   output logic [4*ND-1:0] bcd
);
   localparam int CNT_W = $clog2(W + 1);

   conv_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4*ND+W-1:0]  sh_q, sh_d;
   logic [4*ND-1:0]    adj;

   // Add-3 correction per nibble. Carries only move upward, so keeping
   // just ND nibbles leaves the low ND digits exact even when the
   // binary value has more decimal digits than ND.
   for (genvar g = 0; g < ND; g++) begin : g_adj
      logic [3:0] nib;
      assign nib            = sh_q[W + 4*g +: 4];
      assign adj[4*g +: 4]  = (nib >= 4'd5) ? (nib + 4'd3) : nib;
   end

   assign bcd = sh_q[W +: 4*ND];

   // State, shift counter and double-dabble register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
      end
   end

   // Next state: latch on start, W correct-and-shift steps, one done cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = {{(4*ND){1'b0}}, bin};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_d  = {adj[4*ND-2:0], sh_q[W-1:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seg7_scan_mux                                           |
// | Purpose  : Binary-to-BCD load handshake, atomic display register,  |
// |            N-digit multiplexed 7-segment scan with blanking,       |
// |            overflow dashes and selectable pin polarity.            |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int W          = 16,
   parameter int N          = 4,
   parameter int PRESCALE   = 50000,
   parameter int BLANK_LZ   = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic           clk,
   input  logic           rst,
   seg7_scan_mux_if.slave bus
);
   localparam int          IDX_W     = (N > 1) ? $clog2(N) : 1;
   localparam int          NSLOT     = 1 << IDX_W;
   localparam int          PRE_W     = $clog2(PRESCALE);
   localparam logic [31:0] OVF_LIMIT = pow10(N);

   logic             busy_q;
   logic [W-1:0]     value_q;
   logic             accept;
   logic             conv_done;
   logic [4*N-1:0]   conv_bcd;
   logic [4*N-1:0]   disp_q;
   logic             ovf_q;
   logic [PRE_W-1:0] presc_q;
   logic             tick_q;
   logic [IDX_W-1:0] idx_q;
   logic [N-1:0]     an_q;
   logic [6:0]       seg_q;
   logic [6:0]       glyph [NSLOT];

   assign accept = bus.load & ~busy_q;

   bin2bcd_seq #(
      .W  (W),
      .ND (N)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (bus.value),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Handshake: busy rises on the accepting edge, falls on the commit edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         value_q <= '0;
      end else if (accept) begin
         busy_q  <= 1'b1;
         value_q <= bus.value;
      end else if (conv_done) begin
         busy_q  <= 1'b0;
      end
   end

   // Display register: digits and overflow flag change together at commit only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q <= '0;
         ovf_q  <= 1'b0;
      end else if (conv_done) begin
         disp_q <= conv_bcd;
         ovf_q  <= (32'(value_q) >= OVF_LIMIT);
      end
   end

   // Prescaler wraps at PRESCALE-1; tick_q is the registered wrap strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else if (presc_q == PRE_W'(PRESCALE - 1)) begin
         presc_q <= '0;
         tick_q  <= 1'b1;
      end else begin
         presc_q <= presc_q + 1'b1;
         tick_q  <= 1'b0;
      end
   end

   // Per-digit glyph: dash on overflow, blank for leading zeros above ones
   for (genvar i = 0; i < NSLOT; i++) begin : g_digit
      if (i >= N) begin : g_pad
         assign glyph[i] = SEG_BLANK;
      end else if (i == 0) begin : g_ones
         assign glyph[i] = ovf_q ? SEG_DASH : seg7_encode(disp_q[3:0]);
      end else begin : g_upper
         logic lead_zero;
         assign lead_zero = (BLANK_LZ != 0) && (disp_q[4*N-1:4*i] == '0);
         assign glyph[i]  = ovf_q     ? SEG_DASH  :
                            lead_zero ? SEG_BLANK :
                                        seg7_encode(disp_q[4*i +: 4]);
      end
   end

   // Scan: enable and segments load together from the current index, then index advances
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         an_q  <= '0;
         seg_q <= '0;
      end else if (tick_q) begin
         an_q  <= N'(1) << idx_q;
         seg_q <= glyph[idx_q];
         if (idx_q == IDX_W'(N - 1)) begin
            idx_q <= '0;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;
   assign bus.an       = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
   assign bus.seg      = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;

endmodule
`default_nettype wire
